// File: rtl/trig_pkg.sv
// trig_pkg: shared constants, state encoding and result type for the trig request path
package trig_pkg;
  localparam int ANGLE_W     = 10;
  localparam int LATENCY     = 3;
  localparam int MAX_ANGLE   = 999;
  localparam int DEG_FULL    = 360;
  localparam int DEG_QUARTER = 90;
  localparam logic OP_COS = 1'b0;
  localparam logic OP_SIN = 1'b1;
  typedef enum logic [2:0] {IDLE, REDUCE, MAP, WAIT, CAPTURE, DONE} state_e;
  typedef struct packed {
    logic       sign;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_res_t;
endpackage

// File: rtl/angle_mod360.sv
// angle_mod360: iterative modulo-360 reducer, one subtraction per cycle after a start load
module angle_mod360
  import trig_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [W-1:0] angle_i,
  output logic         ready_o,
  output logic [8:0]   angle_o
);
  logic [W-1:0] acc_q, acc_d;
  always_comb begin
    acc_d = start_i ? angle_i : (acc_q >= W'(DEG_FULL)) ? acc_q - W'(DEG_FULL) : acc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
  assign ready_o = acc_q < W'(DEG_FULL);
  assign angle_o = acc_q[8:0];
endmodule

// File: rtl/trig_sequencer.sv
// trig_sequencer: reduces a SIN/COS request to a cosine angle, drives the cosine unit and captures its BCD result
module trig_sequencer
  import trig_pkg::*;
#(
  parameter int ANGLE_W   = trig_pkg::ANGLE_W,
  parameter int LATENCY   = trig_pkg::LATENCY,
  parameter int MAX_ANGLE = trig_pkg::MAX_ANGLE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               op,
  input  logic [ANGLE_W-1:0] angle,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [8:0]         cos_number,
  input  logic               cos_sign,
  input  logic [3:0]         cos_ones,
  input  logic [3:0]         cos_tens,
  input  logic [3:0]         cos_hund,
  output logic               res_sign,
  output logic [3:0]         res_ones,
  output logic [3:0]         res_tens,
  output logic [3:0]         res_hund
);
  localparam int CW = $clog2(LATENCY) + 1;
  state_e   state_q, state_d;
  logic     op_q, op_d, err_q, err_d, mod_start, mod_ready;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0] num_q, num_d, red, m;
  bcd_res_t res_q, res_d;
  wire over = angle > ANGLE_W'(MAX_ANGLE);
  angle_mod360 #(.W(ANGLE_W)) u_mod (
    .clk     (clk),
    .reset   (reset),
    .start_i (mod_start),
    .angle_i (angle),
    .ready_o (mod_ready),
    .angle_o (red)
  );
  // sin(x) = cos(x-90), wrapped back into 0..359
  assign m = (op_q == OP_SIN) ? ((red >= 9'(DEG_QUARTER)) ? red - 9'(DEG_QUARTER)
                                                          : red + 9'(DEG_FULL - DEG_QUARTER)) : red;
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    res_d     = res_q;
    mod_start = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        op_d  = op;
        err_d = over;
        if (over) begin
          res_d   = '0;
          state_d = DONE;
        end else begin
          mod_start = 1'b1;
          state_d   = REDUCE;
        end
      end
      REDUCE: state_d = mod_ready ? MAP : REDUCE;
      MAP: begin
        num_d   = m;
        cnt_d   = CW'(LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q <= CW'(1)) ? CAPTURE : WAIT;
      end
      CAPTURE: begin
        res_d   = '{sign: cos_sign, hund: cos_hund, tens: cos_tens, ones: cos_ones};
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_COS;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      num_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      res_q   <= res_d;
    end
  end
  assert property (@(posedge clk) disable iff (reset) state_q == MAP |-> m < 9'(DEG_FULL));
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign err        = err_q;
  assign cos_number = num_q;
  assign res_sign   = res_q.sign;
  assign res_hund   = res_q.hund;
  assign res_tens   = res_q.tens;
  assign res_ones   = res_q.ones;
endmodule
